// File: rtl/v_upd_arb.sv
// v_upd_arb: round-robin arbiter for the v list-update bus.
// A grant is withheld while the requester's product id is still inside the issue-spacing window.
module v_upd_arb #(
    parameter int N_REQ         = 4,
    parameter int HAZARD_CYCLES = 4,
    parameter int ID_W          = 8,
    parameter int CMD_W         = 4,
    parameter int KEY_W         = 32,
    parameter int SIZE_W        = 16,
    parameter int SRC_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         i_req_vld,
    input  logic [N_REQ*ID_W-1:0]    i_req_prod_id,
    input  logic [N_REQ*CMD_W-1:0]   i_req_cmd,
    input  logic [N_REQ*KEY_W-1:0]   i_req_key,
    input  logic [N_REQ*SIZE_W-1:0]  i_req_size,
    output logic [N_REQ-1:0]         o_req_rdy,
    input  logic                     i_busy_r,
    output logic                     o_upd_vld_r,
    output logic [ID_W-1:0]          o_upd_prod_id_r,
    output logic [CMD_W-1:0]         o_upd_cmd_r,
    output logic [KEY_W-1:0]         o_upd_key_r,
    output logic [SIZE_W-1:0]        o_upd_size_r,
    output logic [SRC_W-1:0]         o_upd_src_r,
    output logic                     o_hz_stall_r,
    output logic [15:0]              o_hz_stall_cnt_r
);
    localparam int HD = (HAZARD_CYCLES > 1) ? HAZARD_CYCLES - 1 : 1;

    logic [HD-1:0]           hist_vld;
    logic [HD-1:0][ID_W-1:0] hist_id;
    logic [N_REQ-1:0]        hz;
    logic [N_REQ-1:0]        elig;
    logic [SRC_W-1:0]        ptr;
    logic [SRC_W-1:0]        gsel;
    logic                    any_gnt;
    logic [ID_W-1:0]         gid;

    function automatic logic [SRC_W-1:0] wrap(input int v);
        return SRC_W'(v % N_REQ);
    endfunction

    always_comb begin
        hz = '0;
        for (int i = 0; i < N_REQ; i++)
            for (int k = 0; k < HD; k++)
                if (HAZARD_CYCLES > 1 && hist_vld[k] && hist_id[k] == i_req_prod_id[i*ID_W +: ID_W])
                    hz[i] = 1'b1;
        elig = i_req_vld & ~hz;
    end

    // Scan from the far end back to ptr so the closest eligible index wins.
    always_comb begin
        gsel    = '0;
        any_gnt = 1'b0;
        for (int o = N_REQ - 1; o >= 0; o--)
            if (!rst && !i_busy_r && elig[wrap(int'(ptr) + o)]) begin
                gsel    = wrap(int'(ptr) + o);
                any_gnt = 1'b1;
            end
    end

    assign o_req_rdy = any_gnt ? (N_REQ'(1) << gsel) : '0;
    assign gid       = i_req_prod_id[gsel*ID_W +: ID_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            o_upd_vld_r      <= 1'b0;
            o_upd_prod_id_r  <= '0;
            o_upd_cmd_r      <= '0;
            o_upd_key_r      <= '0;
            o_upd_size_r     <= '0;
            o_upd_src_r      <= '0;
            o_hz_stall_r     <= 1'b0;
            o_hz_stall_cnt_r <= '0;
            ptr              <= '0;
            hist_vld         <= '0;
            hist_id          <= '0;
        end else begin
            o_upd_vld_r <= any_gnt;
            if (any_gnt) begin
                o_upd_prod_id_r <= gid;
                o_upd_cmd_r     <= i_req_cmd[gsel*CMD_W +: CMD_W];
                o_upd_key_r     <= i_req_key[gsel*KEY_W +: KEY_W];
                o_upd_size_r    <= i_req_size[gsel*SIZE_W +: SIZE_W];
                o_upd_src_r     <= gsel;
                ptr             <= wrap(int'(gsel) + 1);
            end
            hist_vld[0] <= any_gnt;
            hist_id[0]  <= gid;
            for (int k = 1; k < HD; k++) begin
                hist_vld[k] <= hist_vld[k-1];
                hist_id[k]  <= hist_id[k-1];
            end
            o_hz_stall_r     <= |i_req_vld & ~i_busy_r & ~any_gnt;
            o_hz_stall_cnt_r <= o_hz_stall_cnt_r + 16'(o_hz_stall_r & ~&o_hz_stall_cnt_r);
        end
    end
endmodule
